// File: rtl/inv_sub_bytes.sv
// AES inverse SubBytes: one 32-bit column per cycle through four inverse S-box lanes.
// Optional INV_SUB_BYTES_LUT_REG_EN registers the lane outputs before write-back.
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [2047:0] t;
        t = INV_TBL;
        return t[{~b, 3'b000} +: 8];
    endfunction

    logic [1:0]   fsm_q;
    logic [1:0]   col;
    logic [127:0] state_q;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    // Column 0 sits at [127:96], so the slice base is (3-col)*32 = {~col, 5'b0}.
    assign col_in  = state_q[{~col, 5'b00000} +: 32];
    assign col_out = {inv_sbox(col_in[31:24]), inv_sbox(col_in[23:16]),
                      inv_sbox(col_in[15:8]),  inv_sbox(col_in[7:0])};

`ifdef INV_SUB_BYTES_LUT_REG_EN
    logic [31:0] lut_p1;
    logic        vld_p1;
    logic [1:0]  wcol;
    logic        last;

    // The registered lookup lags the column counter by one.
    assign wcol = col - 2'd1;
    assign last = vld_p1 && (col == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            col     <= 2'd0;
            state_q <= 128'h0;
            lut_p1  <= 32'h0;
            vld_p1  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    vld_p1 <= 1'b0;
                    if (in_valid) begin
                        state_q <= in_state;
                        col     <= 2'd0;
                        fsm_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (vld_p1)
                        state_q[{~wcol, 5'b00000} +: 32] <= lut_p1;
                    if (last) begin
                        vld_p1 <= 1'b0;
                        fsm_q  <= DONE;
                    end else begin
                        lut_p1 <= col_out;
                        vld_p1 <= 1'b1;
                        col    <= col + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        fsm_q <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            col     <= 2'd0;
            state_q <= 128'h0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_state;
                        col     <= 2'd0;
                        fsm_q   <= BUSY;
                    end
                end
                BUSY: begin
                    state_q[{~col, 5'b00000} +: 32] <= col_out;
                    col <= col + 2'd1;
                    if (col == 2'd3)
                        fsm_q <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        fsm_q <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
`endif

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == BUSY);
    assign out_state = state_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed bench for inv_sub_bytes; forward S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_state = 128'h0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_state;
    logic         busy;

`ifdef INV_SUB_BYTES_LUT_REG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

    inv_sub_bytes dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [127:0] map_state(input logic [127:0] s, input logic fwd);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[i*8 +: 8] = fwd ? sbox_t[s[i*8 +: 8]] : inv_t[s[i*8 +: 8]];
        return r;
    endfunction

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Call just after a posedge (+#1) with out_ready high; returns result and latency.
    task automatic txn(input logic [127:0] din, output logic [127:0] dout, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_state = din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        dout = out_state;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] a, b, d, held, ra, rb, orig;
        int lat, n;
        logic seen_idle;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox_t[x] = s;
        end
        for (int x = 0; x < 256; x++) inv_t[sbox_t[x]] = 8'(x);

        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check128("rst_out_state", out_state, 128'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // single known vector with latency and busy
        in_state = 128'h637c7b16_00000000_52ed7cf2_630000ff;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check1("vec_busy", busy, 1'b1);
        check1("vec_in_ready_busy", in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check_int("vec_latency", lat, LAT);
        check128("vec_out", out_state, 128'h000103ff_52525252_48530104_0052527d);
        @(posedge clk); #1;
        check1("vec_idle_in_ready", in_ready, 1'b1);
        check1("vec_idle_out_valid", out_valid, 1'b0);

        // all 256 byte values
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 16; i++) a[i*8 +: 8] = 8'(t*16 + i);
            txn(a, d, lat);
            check128($sformatf("table_%0d", t), map_state(d, 1'b1), a);
        end

        // backpressure in DONE
        a = 128'h00112233_44556677_8899aabb_ccddeeff;
        out_ready = 1'b0;
        in_state = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        held = out_state;
        check128("bp_result", held, map_state(a, 1'b0));
        in_state = ~a;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check1("bp_out_valid", out_valid, 1'b1);
            check128("bp_out_stable", out_state, held);
            check1("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check1("bp_release_out_valid", out_valid, 1'b0);
        check1("bp_release_in_ready", in_ready, 1'b1);
        check1("bp_release_busy", busy, 1'b0);

        // back-to-back with in_valid held high
        a = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        in_state = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_state = b;
        ra = 128'h0;
        n = 0;
        seen_idle = 1'b0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (out_valid) ra = out_state;
            if (!busy) seen_idle = 1'b1;
            if (busy && seen_idle) break;
        end
        in_valid = 1'b0;
        check_int("b2b_issue_interval", n, LAT + 2);
        check128("b2b_first", ra, map_state(a, 1'b0));
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        rb = out_state;
        check128("b2b_second", rb, map_state(b, 1'b0));
        @(posedge clk); #1;

        // reset mid-BUSY
        in_state = 128'hffeeddcc_bbaa9988_77665544_33221100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check1("abort_in_ready", in_ready, 1'b1);
        check1("abort_out_valid", out_valid, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check128("abort_out_state", out_state, 128'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check1("abort_no_stale_valid", out_valid, 1'b0);
        end

        // random round trip
        for (int it = 0; it < 1000; it++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            txn(map_state(orig, 1'b1), d, lat);
            check128("roundtrip", d, orig);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
